// File: rtl/serial_io_buffer.sv
// rtl/serial_io_buffer.sv - FIFO-buffered bridge between CPU MMIO path and the serial byte port.
// Optional internal TX->RX loopback when SERIAL_IO_LOOPBACK_EN is defined.
module serial_io_buffer #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
`ifdef SERIAL_IO_LOOPBACK_EN
  input  logic                      loopback,
`endif
  input  logic [DATA_W-1:0]         cpu_tx_data,
  input  logic                      cpu_tx_wr,
  output logic                      cpu_tx_full,
  output logic                      cpu_tx_overflow,
  output logic [$clog2(TX_DEPTH):0] cpu_tx_count,
  input  logic                      cpu_rx_rd,
  output logic [DATA_W-1:0]         cpu_rx_data,
  output logic                      cpu_rx_empty,
  output logic [$clog2(RX_DEPTH):0] cpu_rx_count,
  output logic [DATA_W-1:0]         serial_out,
  output logic                      serial_wren_out,
  input  logic                      serial_ready_in,
  input  logic [DATA_W-1:0]         serial_in,
  input  logic                      serial_valid_in,
  output logic                      serial_rden_out
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [TAW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TAW:0]      tx_count_q, tx_count_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic [DATA_W-1:0] serial_out_q, serial_out_d;
  logic              serial_wren_q, serial_wren_d;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [RAW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RAW:0]      rx_count_q, rx_count_d;

  logic              lb, rx_space, tx_push, tx_pop, rx_push, rx_pop, rx_ext;
  logic [DATA_W-1:0] tx_head, rx_wdata;

  always_comb begin
`ifdef SERIAL_IO_LOOPBACK_EN
    lb = loopback;
`else
    lb = 1'b0;
`endif
    tx_head  = tx_mem_q[tx_rd_ptr_q];
    rx_space = (rx_count_q != RX_FULL);
    // Full is judged on the pre-edge count, so a push while full drops even if a pop frees a slot.
    tx_push  = cpu_tx_wr && (tx_count_q != TX_FULL);
    tx_pop   = (tx_count_q != '0) && (lb ? rx_space : serial_ready_in);
    rx_ext   = !lb && serial_valid_in && rx_space;
    rx_push  = rx_ext || (lb && tx_pop);
    rx_pop   = cpu_rx_rd && (rx_count_q != '0);
    rx_wdata = lb ? tx_head : serial_in;

    tx_wr_ptr_d   = tx_push ? tx_wr_ptr_q + TAW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d   = tx_pop  ? tx_rd_ptr_q + TAW'(1) : tx_rd_ptr_q;
    tx_count_d    = tx_count_q + {{TAW{1'b0}}, tx_push} - {{TAW{1'b0}}, tx_pop};
    tx_ovf_d      = tx_ovf_q || (cpu_tx_wr && (tx_count_q == TX_FULL));
    serial_wren_d = tx_pop && !lb;
    serial_out_d  = serial_wren_d ? tx_head : serial_out_q;

    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RAW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RAW'(1) : rx_rd_ptr_q;
    rx_count_d  = rx_count_q + {{RAW{1'b0}}, rx_push} - {{RAW{1'b0}}, rx_pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      tx_ovf_q      <= 1'b0;
      serial_out_q  <= '0;
      serial_wren_q <= 1'b0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
    end else begin
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      tx_ovf_q      <= tx_ovf_d;
      serial_out_q  <= serial_out_d;
      serial_wren_q <= serial_wren_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
    end
  end

  // Storage arrays are not reset; occupancy counts alone decide what is valid.
  always_ff @(posedge clock) begin
    if (!reset && tx_push) tx_mem_q[tx_wr_ptr_q] <= cpu_tx_data;
    if (!reset && rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_wdata;
  end

  assign cpu_tx_full     = (tx_count_q == TX_FULL);
  assign cpu_tx_overflow = tx_ovf_q;
  assign cpu_tx_count    = tx_count_q;
  assign cpu_rx_empty    = (rx_count_q == '0);
  assign cpu_rx_count    = rx_count_q;
  assign cpu_rx_data     = cpu_rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign serial_out      = serial_out_q;
  assign serial_wren_out = serial_wren_q;
  assign serial_rden_out = rx_ext;

endmodule

// File: tb/tb_serial_io_buffer.sv
// tb/tb_serial_io_buffer.sv - randomized and directed bench for serial_io_buffer against a queue model.
module tb_serial_io_buffer;
  localparam int TXD = 16;
  localparam int RXD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       lb = 1'b0;
  logic [7:0] cpu_tx_data = '0;
  logic       cpu_tx_wr = 1'b0;
  logic       cpu_tx_full, cpu_tx_overflow;
  logic [4:0] cpu_tx_count;
  logic       cpu_rx_rd = 1'b0;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_empty;
  logic [3:0] cpu_rx_count;
  logic [7:0] serial_out;
  logic       serial_wren_out;
  logic       serial_ready_in = 1'b0;
  logic [7:0] serial_in = '0;
  logic       serial_valid_in = 1'b0;
  logic       serial_rden_out;

  serial_io_buffer #(.DATA_W(8), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clock(clock), .reset(reset),
`ifdef SERIAL_IO_LOOPBACK_EN
    .loopback(lb),
`endif
    .cpu_tx_data(cpu_tx_data), .cpu_tx_wr(cpu_tx_wr), .cpu_tx_full(cpu_tx_full),
    .cpu_tx_overflow(cpu_tx_overflow), .cpu_tx_count(cpu_tx_count),
    .cpu_rx_rd(cpu_rx_rd), .cpu_rx_data(cpu_rx_data), .cpu_rx_empty(cpu_rx_empty),
    .cpu_rx_count(cpu_rx_count), .serial_out(serial_out), .serial_wren_out(serial_wren_out),
    .serial_ready_in(serial_ready_in), .serial_in(serial_in),
    .serial_valid_in(serial_valid_in), .serial_rden_out(serial_rden_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, first_wren = -1, rden_hi_cnt = 0, push_cyc = 0;
  logic chk_en = 1'b0, rden_seen = 1'b0, prod_on = 1'b0;
  logic [7:0] txq[$], rxq[$], out_log[$], pop_log[$], exp_log[$];
  logic       m_ovf = 1'b0, m_wren = 1'b0;
  logic [7:0] m_sout = '0, head;
  int         tn, rn;
  logic       tpop, racc, rpop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain queues updated from the inputs seen at each rising edge.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      txq.delete(); rxq.delete();
      m_ovf = 1'b0; m_wren = 1'b0; m_sout = '0;
    end else begin
      tn = txq.size(); rn = rxq.size();
      tpop = (tn > 0) && (lb ? (rn < RXD) : serial_ready_in);
      racc = !lb && serial_valid_in && (rn < RXD);
      rpop = cpu_rx_rd && (rn > 0);
      m_wren = 1'b0;
      head = '0;
      if (tpop) head = txq.pop_front();
      if (tpop && !lb) begin m_sout = head; m_wren = 1'b1; end
      if (cpu_tx_wr) begin
        if (tn < TXD) txq.push_back(cpu_tx_data);
        else m_ovf = 1'b1;
      end
      if (rpop) void'(rxq.pop_front());
      if (racc) rxq.push_back(serial_in);
      if (tpop && lb) rxq.push_back(head);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("serial_wren_out", {31'b0, serial_wren_out}, {31'b0, m_wren});
      chk("serial_out", {24'b0, serial_out}, {24'b0, m_sout});
      chk("cpu_tx_count", {27'b0, cpu_tx_count}, txq.size());
      chk("cpu_tx_full", {31'b0, cpu_tx_full}, {31'b0, txq.size() == TXD});
      chk("cpu_tx_overflow", {31'b0, cpu_tx_overflow}, {31'b0, m_ovf});
      chk("cpu_rx_count", {28'b0, cpu_rx_count}, rxq.size());
      chk("cpu_rx_empty", {31'b0, cpu_rx_empty}, {31'b0, rxq.size() == 0});
      if (rxq.size() > 0) chk("cpu_rx_data", {24'b0, cpu_rx_data}, {24'b0, rxq[0]});
      chk("serial_rden_out", {31'b0, serial_rden_out},
          {31'b0, !lb && serial_valid_in && (rxq.size() < RXD)});
    end
    rden_seen = serial_rden_out;
    if (serial_rden_out) rden_hi_cnt++;
    if (serial_wren_out) begin
      out_log.push_back(serial_out);
      if (first_wren < 0) first_wren = cyc;
    end
  end

  task automatic cycle();
    @(posedge clock);
    #2;
    if (prod_on && rden_seen) serial_in = serial_in + 8'd1;
  endtask

  initial begin
    repeat (3) cycle();
    chk_en = 1'b1;
    chk("reset wren", {31'b0, serial_wren_out}, 0);
    chk("reset sout", {24'b0, serial_out}, 0);
    chk("reset tx_count", {27'b0, cpu_tx_count}, 0);
    chk("reset rx_count", {28'b0, cpu_rx_count}, 0);
    chk("reset tx_full", {31'b0, cpu_tx_full}, 0);
    chk("reset rx_empty", {31'b0, cpu_rx_empty}, 1);
    chk("reset rx_data", {24'b0, cpu_rx_data}, 0);
    chk("reset overflow", {31'b0, cpu_tx_overflow}, 0);
    reset = 1'b0;

    // 'H','i' back to back, ready held high.
    serial_ready_in = 1'b1; out_log.delete(); first_wren = -1;
    push_cyc = cyc; cpu_tx_wr = 1'b1; cpu_tx_data = 8'h48; cycle();
    cpu_tx_data = 8'h69; cycle();
    cpu_tx_wr = 1'b0; repeat (5) cycle();
    chk("hi count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("hi word0", {24'b0, out_log[0]}, 32'h48);
      chk("hi word1", {24'b0, out_log[1]}, 32'h69);
    end
    chk("hi latency", first_wren, push_cyc + 2);

    // Overflow: 17 pushes with the sink stalled.
    serial_ready_in = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpu_tx_wr = 1'b1; cpu_tx_data = 8'(i); cycle();
      if (i == 15) begin
        chk("full after 16", {31'b0, cpu_tx_full}, 1);
        chk("count after 16", {27'b0, cpu_tx_count}, 16);
        chk("no ovf after 16", {31'b0, cpu_tx_overflow}, 0);
      end
    end
    chk("ovf after 17", {31'b0, cpu_tx_overflow}, 1);
    cpu_tx_wr = 1'b0; out_log.delete(); serial_ready_in = 1'b1;
    repeat (22) cycle();
    chk("drain count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) chk("drain order", {24'b0, out_log[i]}, i);
    chk("ovf sticky", {31'b0, cpu_tx_overflow}, 1);
    reset = 1'b1; cycle(); reset = 1'b0;

    // RX fill to capacity, then one pop lets the ninth word in.
    rden_hi_cnt = 0; serial_in = 8'h10; serial_valid_in = 1'b1; prod_on = 1'b1;
    repeat (12) cycle();
    chk("rx full count", {28'b0, cpu_rx_count}, 8);
    chk("rx rden cycles", rden_hi_cnt, 8);
    chk("rx rden low", {31'b0, serial_rden_out}, 0);
    pop_log.delete();
    cpu_rx_rd = 1'b1; pop_log.push_back(cpu_rx_data); cycle();
    cpu_rx_rd = 1'b0; repeat (3) cycle();
    chk("rx 0x18 taken", {24'b0, serial_in}, 32'h19);
    chk("rx rden cycles 2", rden_hi_cnt, 9);
    serial_valid_in = 1'b0; prod_on = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (cpu_rx_empty) cpu_rx_rd = 1'b0;
      else begin cpu_rx_rd = 1'b1; pop_log.push_back(cpu_rx_data); end
      cycle();
    end
    cpu_rx_rd = 1'b0;
    chk("rx pop count", pop_log.size(), 9);
    for (int i = 0; i < 9 && i < pop_log.size(); i++) chk("rx pop order", {24'b0, pop_log[i]}, 32'h10 + i);

    // 40 words through TX with ready 3-on/1-off, random RX traffic alongside.
    out_log.delete(); exp_log.delete();
    for (int i = 0; i < 40; i++) begin
      cpu_tx_wr = 1'b1; cpu_tx_data = 8'($urandom); exp_log.push_back(cpu_tx_data);
      serial_ready_in = (i % 4) != 3;
      serial_valid_in = 1'($urandom); serial_in = 8'($urandom); cpu_rx_rd = 1'($urandom);
      cycle();
    end
    cpu_tx_wr = 1'b0; serial_ready_in = 1'b1; serial_valid_in = 1'b0; cpu_rx_rd = 1'b0;
    repeat (20) cycle();
    chk("stream count", out_log.size(), 40);
    for (int i = 0; i < 40 && i < out_log.size(); i++) chk("stream word", {24'b0, out_log[i]}, {24'b0, exp_log[i]});
    chk("stream tx empty", {27'b0, cpu_tx_count}, 0);

    // Fully random traffic, model checked every cycle.
    for (int i = 0; i < 400; i++) begin
      cpu_tx_wr = ($urandom_range(0, 3) != 0); cpu_tx_data = 8'($urandom);
      serial_ready_in = ($urandom_range(0, 2) == 0);
      serial_valid_in = 1'($urandom); serial_in = 8'($urandom);
      cpu_rx_rd = ($urandom_range(0, 2) == 0);
      cycle();
    end
    cpu_tx_wr = 1'b0; serial_valid_in = 1'b0; cpu_rx_rd = 1'b0;

    // Reset while TX holds five words and the sink becomes ready.
    reset = 1'b1; cycle(); reset = 1'b0;
    serial_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin cpu_tx_wr = 1'b1; cpu_tx_data = 8'(8'hC0 + i); cycle(); end
    cpu_tx_wr = 1'b0;
    chk("pre-reset count", {27'b0, cpu_tx_count}, 5);
    out_log.delete(); serial_ready_in = 1'b1; reset = 1'b1; cycle();
    chk("wren after reset", {31'b0, serial_wren_out}, 0);
    reset = 1'b0; repeat (6) cycle();
    chk("no stale word", out_log.size(), 0);
    chk("post-reset count", {27'b0, cpu_tx_count}, 0);

`ifdef SERIAL_IO_LOOPBACK_EN
    out_log.delete(); lb = 1'b1;
    cpu_tx_wr = 1'b1; cpu_tx_data = 8'hA5; cycle();
    cpu_tx_data = 8'h5A; cycle();
    cpu_tx_wr = 1'b0; repeat (4) cycle();
    chk("lb no wren", out_log.size(), 0);
    chk("lb head 0", {24'b0, cpu_rx_data}, 32'hA5);
    cpu_rx_rd = 1'b1; cycle(); cpu_rx_rd = 1'b0;
    chk("lb head 1", {24'b0, cpu_rx_data}, 32'h5A);
    lb = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_io_buffer.md
Name: serial_io_buffer

Overview:
- Parametrised, FIFO-buffered serial port bridge between the processor's memory-mapped I/O store/load path and the external serial byte interface (serial_out / serial_wren_out / serial_ready_in, serial_in / serial_valid_in / serial_rden_out).
- Successor to the unbuffered direct-drive port. Adds configurable data width, independent TX/RX depths, occupancy counts and a sticky overflow flag.
- The CPU no longer stalls on each character; the block drains TX and fills RX autonomously under handshake.

Parameters:
- DATA_W, 8: serial word width in bits.
- TX_DEPTH, 16: TX FIFO entries; power of two, >= 2.
- RX_DEPTH, 8: RX FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_tx_data  in  DATA_W  word to transmit.
- cpu_tx_wr  in  1  push cpu_tx_data into TX FIFO.
- cpu_tx_full  out  1  TX FIFO full.
- cpu_tx_overflow  out  1  sticky: a push was dropped.
- cpu_tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy.
- cpu_rx_rd  in  1  pop RX head.
- cpu_rx_data  out  DATA_W  RX head (show-ahead).
- cpu_rx_empty  out  1  RX FIFO empty.
- cpu_rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy.
- serial_out  out  DATA_W  outgoing word.
- serial_wren_out  out  1  active-high; serial_out valid this cycle.
- serial_ready_in  in  1  active-high; sink can accept a word.
- serial_in  in  DATA_W  incoming word.
- serial_valid_in  in  1  active-high; serial_in valid.
- serial_rden_out  out  1  active-high; word on serial_in consumed this cycle.

Behaviour:
- Reset values: serial_out=0, serial_wren_out=0, cpu_tx_overflow=0, counts=0, cpu_tx_full=0, cpu_rx_empty=1, cpu_rx_data=0. FIFO pointers cleared. Reset mid-transfer discards all buffered data; no word is emitted in the cycle after reset asserts.
- TX push: cpu_tx_wr with cpu_tx_count<TX_DEPTH writes at the edge. A push while full is dropped and sets cpu_tx_overflow, which holds until reset. This applies even when a pop occurs in the same cycle; full is judged on the pre-edge count.
- TX drain: at each edge where TX is non-empty and serial_ready_in=1, pop the head and register it into serial_out, with serial_wren_out=1 for the following cycle. Otherwise serial_wren_out=0 and serial_out holds its last value.
- TX rate and latency: at most one word per cycle. A push sampled at edge k into an empty FIFO produces serial_wren_out high in the cycle after edge k+1, i.e. 2-cycle latency.
- TX count: push and pop in the same cycle leave cpu_tx_count unchanged.
- RX accept: serial_rden_out = serial_valid_in && (cpu_rx_count<RX_DEPTH), combinational. A word is written at the edge when serial_rden_out=1. A producer seeing rden low must hold, so RX never loses data.
- RX read: cpu_rx_data always shows the head entry. cpu_rx_rd when non-empty pops at the edge; cpu_rx_rd when empty is ignored with no state change. Simultaneous RX push and pop is legal at any occupancy, including full with a pop: rden stays low when full, so the pop just frees a slot.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are tracked separately, so full and empty are unambiguous.
- No combinational path from cpu_* inputs to serial_* outputs.

Optional Feature:
- SERIAL_IO_LOOPBACK_EN defined: adds input port loopback (1 bit).
  - While loopback=1, TX pops feed the RX FIFO instead of serial_out, and serial_wren_out is forced 0.
  - TX pops only when RX has space (replaces the serial_ready_in condition).
  - serial_rden_out is forced 0; external RX input is ignored.
  - Changing loopback takes effect at the next edge; words already in a FIFO are not lost.
- Undefined: no loopback port and no loopback logic.

Test Plan:
- Reset, then push 'H','i' on consecutive cycles with ready=1 -> serial_wren_out high for exactly 2 consecutive cycles with serial_out 0x48 then 0x69; first high 2 cycles after the first push.
- Hold serial_ready_in=0 and push 17 words into TX_DEPTH=16 -> cpu_tx_full=1 and cpu_tx_count=16 after 16 pushes; 17th dropped with cpu_tx_overflow=1; after ready=1, exactly 16 words emerge in order 0..15 and overflow stays 1.
- Drive serial_valid_in=1 with words 0x10..0x18, never pop, RX_DEPTH=8 -> serial_rden_out high for 8 cycles, then low; cpu_rx_count=8. Pop once -> rden re-asserts and 0x18 is accepted; popped sequence is 0x10..0x18.
- Push and drain continuously for 40 words, toggling ready with a 3-on/1-off pattern -> no loss or duplication; pointers wrap past depth; count returns to 0.
- Assert reset while TX holds 5 words and ready=1 -> serial_wren_out=0 from the edge after reset; counts 0; no stale word appears after release.
- With SERIAL_IO_LOOPBACK_EN and loopback=1, push 0xA5,0x5A -> serial_wren_out never high; cpu_rx_data reads 0xA5 then 0x5A.
